// File: rtl/hilo_div_sched_pkg.sv
// Shared SPECIAL funct codes, FSM encoding and defaults for the HI/LO divide scheduler.
package hilo_div_sched_pkg;

    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    localparam int unsigned DIV_TIMEOUT_DEFAULT = 40;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StHold = 2'b10
    } state_e;

    function automatic logic is_div_funct(input logic [5:0] funct);
        return (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
    endfunction

    function automatic logic is_mul_funct(input logic [5:0] funct);
        return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
    endfunction

endpackage

// File: rtl/hilo_div_sched_hilo_reg.sv
// Architectural HI/LO register pair; divider > multiplier > MTHI/MTLO write priority.
module hilo_reg
    import hilo_div_sched_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              div_we,
    input  logic [DATA_W-1:0] div_hi,
    input  logic [DATA_W-1:0] div_lo,
    input  logic              mul_we,
    input  logic [DATA_W-1:0] mul_hi,
    input  logic [DATA_W-1:0] mul_lo,
    input  logic              mthi_we,
    input  logic              mtlo_we,
    input  logic [DATA_W-1:0] mt_data,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    // Pick the highest-priority writer for each half.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (div_we) begin
            hi_d = div_hi;
            lo_d = div_lo;
        end else if (mul_we) begin
            hi_d = mul_hi;
            lo_d = mul_lo;
        end else begin
            if (mthi_we) hi_d = mt_data;
            if (mtlo_we) lo_d = mt_data;
        end
    end

    // HI/LO state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/hilo_div_sched.sv
// EX-stage divide sequencer: issues DIV/DIVU, stalls until done, guards with a watchdog,
// and arbitrates HI/LO writes.
module hilo_div_sched
    import hilo_div_sched_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DIV_TIMEOUT = DIV_TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    input  logic [5:0]          ex_funct,
    input  logic [DATA_W-1:0]   ex_op1,
    input  logic [DATA_W-1:0]   ex_op2,
    input  logic                ex_hold,
    input  logic                flush,
    input  logic [2*DATA_W-1:0] mul_result,
    output logic                div_start,
    output logic                div_signed,
    output logic [DATA_W-1:0]   div_op1,
    output logic [DATA_W-1:0]   div_op2,
    output logic                div_cancel,
    input  logic                div_done,
    input  logic [2*DATA_W-1:0] div_result,
    output logic                stall_req,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o,
    output logic                div_err
);

    localparam int unsigned CNT_W = $clog2(DIV_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              div_start_q, div_cancel_q, div_signed_q, div_err_q;
    logic [DATA_W-1:0] div_op1_q, div_op2_q;

    logic is_div, issue, timeout, cancel, div_we, mul_we, mthi_we, mtlo_we, nondiv_ok;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic; flush outranks a coincident done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (issue) state_d = StRun;
            StRun: begin
                if (flush)         state_d = StIdle;
                else if (div_done) state_d = ex_hold ? StHold : StIdle;
                else if (timeout)  state_d = StIdle;
            end
            StHold: if (!ex_hold || flush) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Decoded controls and combinational outputs.
    always_comb begin
        is_div    = ex_valid && is_div_funct(ex_funct) && !flush;
        issue     = (state_q == StIdle) && is_div && (ex_op2 != '0);
        timeout   = (state_q == StRun) && !div_done && !flush
                    && (cnt_q == CNT_W'(DIV_TIMEOUT - 1));
        // A flush that coincides with done needs no abort: the divider is already finished.
        cancel    = ((state_q == StRun) && flush && !div_done) || timeout;
        stall_req = issue || ((state_q == StRun) && !div_done);
        div_we    = (state_q == StRun) && div_done && !flush;
        nondiv_ok = (state_q == StIdle) && ex_valid && !flush && !ex_hold;
        mul_we    = nondiv_ok && is_mul_funct(ex_funct);
        mthi_we   = nondiv_ok && (ex_funct == FUNCT_MTHI);
        mtlo_we   = nondiv_ok && (ex_funct == FUNCT_MTLO);
    end

    // Divider interface registers, watchdog counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_start_q  <= 1'b0;
            div_cancel_q <= 1'b0;
            div_signed_q <= 1'b0;
            div_op1_q    <= '0;
            div_op2_q    <= '0;
            div_err_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            div_start_q  <= issue;
            div_cancel_q <= cancel;
            if (issue) begin
                div_op1_q    <= ex_op1;
                div_op2_q    <= ex_op2;
                div_signed_q <= (ex_funct == FUNCT_DIV);
                cnt_q        <= '0;
            end else if (state_q == StRun) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (timeout) div_err_q <= 1'b1;
        end
    end

    assign div_start  = div_start_q;
    assign div_cancel = div_cancel_q;
    assign div_signed = div_signed_q;
    assign div_op1    = div_op1_q;
    assign div_op2    = div_op2_q;
    assign div_err    = div_err_q;

    hilo_reg #(
        .DATA_W (DATA_W)
    ) u_hilo_reg (
        .clk     (clk),
        .rst     (rst),
        .div_we  (div_we),
        .div_hi  (div_result[2*DATA_W-1:DATA_W]),
        .div_lo  (div_result[DATA_W-1:0]),
        .mul_we  (mul_we),
        .mul_hi  (mul_result[2*DATA_W-1:DATA_W]),
        .mul_lo  (mul_result[DATA_W-1:0]),
        .mthi_we (mthi_we),
        .mtlo_we (mtlo_we),
        .mt_data (ex_op1),
        .hi      (hi_o),
        .lo      (lo_o)
    );

endmodule

// File: tb/tb_hilo_div_sched.sv
// Directed + randomized bench for hilo_div_sched with an arithmetic HI/LO reference model.
module tb_hilo_div_sched;
    import hilo_div_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_hold, flush, div_done;
    logic [5:0]  ex_funct;
    logic [31:0] ex_op1, ex_op2;
    logic [63:0] mul_result, div_result;
    logic        div_start, div_signed, div_cancel, stall_req, div_err;
    logic [31:0] div_op1, div_op2, hi_o, lo_o;

    int total = 0;
    int bad   = 0;
    int start_cnt = 0, cancel_cnt = 0, stall_cnt = 0;

    logic [31:0] hi_m, lo_m;

    always #5 clk = ~clk;

    hilo_div_sched dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_funct   (ex_funct),
        .ex_op1     (ex_op1),
        .ex_op2     (ex_op2),
        .ex_hold    (ex_hold),
        .flush      (flush),
        .mul_result (mul_result),
        .div_start  (div_start),
        .div_signed (div_signed),
        .div_op1    (div_op1),
        .div_op2    (div_op2),
        .div_cancel (div_cancel),
        .div_done   (div_done),
        .div_result (div_result),
        .stall_req  (stall_req),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .div_err    (div_err)
    );

    // Pulse/level counters sampled mid-cycle.
    always @(negedge clk) begin
        if (div_start === 1'b1)  start_cnt++;
        if (div_cancel === 1'b1) cancel_cnt++;
        if (stall_req === 1'b1)  stall_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_hilo(input string tag);
        check({tag, "_hi"}, hi_o, hi_m);
        check({tag, "_lo"}, lo_o, lo_m);
    endtask

    // Full divide: issue, lat RUN cycles before done, optional hold cycles after done.
    task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input int lat, input int hold);
        int s0, t0;
        logic [31:0] q, r;
        if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        s0 = start_cnt;
        t0 = stall_cnt;
        ex_valid = 1'b1;
        ex_funct = sgn ? FUNCT_DIV : FUNCT_DIVU;
        ex_op1   = a;
        ex_op2   = b;
        ex_hold  = 1'b0;
        #1 check("issue_stall", stall_req, 1);
        tick();
        check("div_op1", div_op1, a);
        check("div_op2", div_op2, b);
        check("div_signed", div_signed, sgn);
        repeat (lat) tick();
        div_done   = 1'b1;
        div_result = {r, q};
        ex_hold    = (hold > 0);
        #1 check("done_stall", stall_req, 0);
        tick();
        div_done = 1'b0;
        hi_m = r;
        lo_m = q;
        check_hilo("div");
        repeat (hold) tick();
        ex_hold = 1'b0;
        if (hold > 0) tick();
        ex_valid = 1'b0;
        check("div_starts", start_cnt - s0, 1);
        check("div_stall_cycles", stall_cnt - t0, lat + 1);
    endtask

    task automatic nondiv(input logic [5:0] f, input logic [31:0] op, input logic [63:0] mp,
                          input bit hold, input bit fl);
        ex_valid   = 1'b1;
        ex_funct   = f;
        ex_op1     = op;
        mul_result = mp;
        ex_hold    = hold;
        flush      = fl;
        #1 check("nondiv_stall", stall_req, 0);
        tick();
        ex_valid = 1'b0;
        ex_hold  = 1'b0;
        flush    = 1'b0;
        if (!hold && !fl) begin
            if (f == FUNCT_MULT || f == FUNCT_MULTU) {hi_m, lo_m} = mp;
            else if (f == FUNCT_MTHI) hi_m = op;
            else if (f == FUNCT_MTLO) lo_m = op;
        end
        check_hilo("nondiv");
    endtask

    initial begin
        int s0, c0;
        rst = 1'b1; ex_valid = 1'b0; ex_hold = 1'b0; flush = 1'b0; div_done = 1'b0;
        ex_funct = 6'h0; ex_op1 = '0; ex_op2 = '0; mul_result = '0; div_result = '0;
        hi_m = '0; lo_m = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_hi", hi_o, 0);
        check("rst_lo", lo_o, 0);
        check("rst_err", div_err, 0);
        check("rst_start", div_start, 0);
        check("rst_cancel", div_cancel, 0);
        check("rst_stall", stall_req, 0);
        check("rst_op1", div_op1, 0);
        check("rst_signed", div_signed, 0);

        // DIVU 100/7, done after 33 RUN cycles -> 34 stall cycles.
        run_div(1'b0, 32'd100, 32'd7, 33, 0);
        check("divu_hi_val", hi_o, 32'd2);
        check("divu_lo_val", lo_o, 32'd14);

        // DIV -7/2 with 3 hold cycles after done.
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 34, 3);
        check("div_neg_hi", hi_o, 32'hFFFF_FFFF);
        check("div_neg_lo", lo_o, 32'hFFFF_FFFD);

        // Divide by zero is dropped.
        nondiv(FUNCT_MTHI, 32'h11, 64'h0, 1'b0, 1'b0);
        nondiv(FUNCT_MTLO, 32'h22, 64'h0, 1'b0, 1'b0);
        s0 = start_cnt;
        ex_valid = 1'b1; ex_funct = FUNCT_DIV; ex_op1 = 32'd123; ex_op2 = 32'd0;
        #1 check("dz_stall0", stall_req, 0);
        tick();
        check("dz_stall1", stall_req, 0);
        check("dz_start", div_start, 0);
        tick();
        ex_valid = 1'b0;
        check("dz_starts", start_cnt - s0, 0);
        check("dz_hi", hi_o, 32'h11);
        check("dz_lo", lo_o, 32'h22);

        // Flush 10 cycles into RUN; a late done is ignored.
        c0 = cancel_cnt;
        ex_valid = 1'b1; ex_funct = FUNCT_DIVU; ex_op1 = 32'd1000; ex_op2 = 32'd3;
        tick();
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0; ex_valid = 1'b0;
        check("fl_cancel", div_cancel, 1);
        check("fl_stall", stall_req, 0);
        tick();
        check("fl_cancel_drop", div_cancel, 0);
        div_done = 1'b1; div_result = 64'h1234_5678_9ABC_DEF0;
        tick();
        div_done = 1'b0;
        check_hilo("fl_late_done");
        check("fl_cancel_pulses", cancel_cnt - c0, 1);

        // Flush coincident with done: no write, no cancel.
        c0 = cancel_cnt;
        ex_valid = 1'b1; ex_funct = FUNCT_DIVU; ex_op1 = 32'd50; ex_op2 = 32'd5;
        tick();
        repeat (20) tick();
        div_done = 1'b1; flush = 1'b1; div_result = 64'hAAAA_BBBB_CCCC_DDDD;
        tick();
        div_done = 1'b0; flush = 1'b0; ex_valid = 1'b0;
        check("flco_cancel", div_cancel, 0);
        check_hilo("flco");
        tick();
        check("flco_cancel_pulses", cancel_cnt - c0, 0);

        // Watchdog: never done; abort after 40 RUN cycles.
        ex_valid = 1'b1; ex_funct = FUNCT_DIVU; ex_op1 = 32'd5; ex_op2 = 32'd1;
        tick();
        repeat (39) tick();
        check("wd_pre_cancel", div_cancel, 0);
        check("wd_pre_err", div_err, 0);
        ex_valid = 1'b0;
        tick();
        check("wd_cancel", div_cancel, 1);
        check("wd_err", div_err, 1);
        check("wd_stall", stall_req, 0);
        tick();
        check("wd_cancel_drop", div_cancel, 0);
        check_hilo("wd");
        run_div(1'b0, 32'd9, 32'd3, 33, 0);
        check("wd_after_hi", hi_o, 32'd0);
        check("wd_after_lo", lo_o, 32'd3);
        check("wd_err_sticky", div_err, 1);

        // MULT, MTHI, MTLO back to back.
        nondiv(FUNCT_MULT, 32'h0, 64'h0000_0001_8000_0000, 1'b0, 1'b0);
        check("mult_hi", hi_o, 32'h1);
        check("mult_lo", lo_o, 32'h8000_0000);
        nondiv(FUNCT_MTHI, 32'hDEAD, 64'h0, 1'b0, 1'b0);
        nondiv(FUNCT_MTLO, 32'hBEEF, 64'h0, 1'b0, 1'b0);
        check("mt_hi", hi_o, 32'hDEAD);
        check("mt_lo", lo_o, 32'hBEEF);

        // Reset in the middle of RUN.
        ex_valid = 1'b1; ex_funct = FUNCT_DIV; ex_op1 = 32'd77; ex_op2 = 32'd5;
        tick();
        repeat (5) tick();
        rst = 1'b1; ex_valid = 1'b0;
        tick();
        check("mrst_hi", hi_o, 0);
        check("mrst_lo", lo_o, 0);
        check("mrst_err", div_err, 0);
        check("mrst_start", div_start, 0);
        check("mrst_cancel", div_cancel, 0);
        check("mrst_stall", stall_req, 0);
        check("mrst_op1", div_op1, 0);
        check("mrst_op2", div_op2, 0);
        check("mrst_signed", div_signed, 0);
        rst = 1'b0;
        hi_m = '0; lo_m = '0;
        tick();
        check("mrst_no_cancel", div_cancel, 0);

        // Randomized mix against the model.
        for (int i = 0; i < 24; i++) begin
            int op;
            logic [31:0] a, b;
            op = $urandom_range(0, 5);
            a  = $urandom;
            b  = $urandom;
            case (op)
                0, 1: begin
                    if (b == 32'h0) b = 32'd1;
                    if (op == 0 && b == 32'hFFFF_FFFF) b = 32'd3;
                    run_div(op == 0, a, b, $urandom_range(33, 35), $urandom_range(0, 2));
                end
                2: nondiv(FUNCT_MULT, a, {a, b}, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0);
                3: nondiv(FUNCT_MULTU, a, {b, a}, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0);
                4: nondiv(FUNCT_MTHI, a, {b, b}, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0);
                default: nondiv(FUNCT_MTLO, a, {b, b}, $urandom_range(0, 3) == 0,
                                $urandom_range(0, 3) == 0);
            endcase
            check_hilo("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
